// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the multicycle CPU.
// Holds the PC and the instruction register, and fetches instruction words
// over a REQ/ACK handshake with instruction memory.
// Optional feature macro: FETCH_TIMEOUT_EN (bounds each fetch to TIMEOUT_CYC
// request cycles and raises a sticky FETCH_ERR on expiry).
module fetch_unit #(
   parameter int              PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              TIMEOUT_CYC = 15
) (
   input  logic            CLK,
   input  logic            RST_F,
   input  logic            PC_SEL,
   input  logic            PC_WRITE,
   input  logic            PC_RST,
   input  logic            BR_SEL,
   output logic            IMEM_REQ,
   output logic [PC_W-1:0] IMEM_ADDR,
   input  logic [31:0]     IMEM_DATA,
   input  logic            IMEM_ACK,
   output logic [31:0]     INSTR,
   output logic [3:0]      OPCODE,
   output logic [3:0]      MM,
   output logic [PC_W-1:0] PC_OUT,
   output logic            INSTR_VALID,
   output logic            HALTED,
   output logic            FETCH_ERR
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [3:0] OP_HLT = 4'hF;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [31:0]     ir_q;
   logic            req_q;
   logic            valid_q;
   logic            halted_q;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
`endif

   // Next-PC selection. PC_W never exceeds 16, so truncating the sign-extended
   // 16-bit offset to PC_W bits is simply IR[PC_W-1:0]; the add wraps mod 2^PC_W.
   always_comb begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      if (PC_SEL) begin
         if (BR_SEL) begin
            pc_d = pc_q + ir_q[PC_W-1:0];
         end else begin
            pc_d = ir_q[PC_W-1:0];
         end
      end
   end

   // Fetch FSM with all state and handshake outputs registered.
   always_ff @(posedge CLK) begin
      if (!RST_F) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else if (PC_RST) begin
         // Soft reset: IR is kept, any in-flight ACK this cycle is dropped.
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_q    <= 1'b1;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_REQ: begin
               if (IMEM_ACK) begin
                  ir_q    <= IMEM_DATA;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= S_HOLD;
                  if (IMEM_DATA[31:28] == OP_HLT) begin
                     halted_q <= 1'b1;
                  end
`ifdef FETCH_TIMEOUT_EN
               end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  // Memory never answered: park on a NOOP and flag the error.
                  ir_q    <= '0;
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
`endif
               end
            end
            S_HOLD: begin
               if (PC_WRITE && !halted_q) begin
                  pc_q    <= pc_d;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign IMEM_REQ    = req_q;
   assign IMEM_ADDR   = pc_q;
   assign INSTR       = ir_q;
   assign OPCODE      = ir_q[31:28];
   assign MM          = ir_q[27:24];
   assign PC_OUT      = pc_q;
   assign INSTR_VALID = valid_q;
   assign HALTED      = halted_q;
`ifdef FETCH_TIMEOUT_EN
   assign FETCH_ERR   = err_q;
`else
   assign FETCH_ERR   = 1'b0;
`endif

endmodule
